// File: rtl/tinuc_hazard_ctrl.sv
// TinuC hazard/forwarding controller: tracks in-flight destinations over DEPTH post-ID stages.
// Define TINUC_HZD_PERF_EN to build the stall/flush performance counters.
module tinuc_hazard_ctrl #(
    parameter int  NREG     = 32,
    parameter int  LOAD_LAT = 1,
    localparam int AW       = $clog2(NREG),
    localparam int DEPTH    = 2 + LOAD_LAT,
    localparam int SW       = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_load,
    input  logic          flush,
    input  logic          hold,
    output logic          stall,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          ex_kill,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          load;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [AW-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic               use1_q, use1_d, use2_q, use2_d;
    logic               issue;

    function automatic logic producing(entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

    // First stage index from which this entry's result can be forwarded.
    function automatic int ready_idx(entry_t e);
        return e.load ? 1 + LOAD_LAT : 1;
    endfunction

    always_comb begin
        stall = 1'b0;
        for (int j = 0; j <= DEPTH - 2; j++) begin
            if (producing(ent_q[j]) && (j + 1 < ready_idx(ent_q[j])) &&
                ((id_use1 && (id_rs1 == ent_q[j].rd)) ||
                 (id_use2 && (id_rs2 == ent_q[j].rd))))
                stall = 1'b1;
        end
        if (!id_valid || flush || hold)
            stall = 1'b0;
    end

    // Scan oldest to youngest so the youngest forwardable match overwrites the rest.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (producing(ent_q[k]) && (k >= ready_idx(ent_q[k]))) begin
                if (use1_q && (rs1_q == ent_q[k].rd))
                    fwd_a = SW'(k);
                if (use2_q && (rs2_q == ent_q[k].rd))
                    fwd_b = SW'(k);
            end
        end
        if (!ent_q[0].valid) begin
            fwd_a = '0;
            fwd_b = '0;
        end
    end

    assign ex_kill = !ent_q[0].valid;
    assign issue   = id_valid && !stall && !flush;

    always_comb begin
        ent_d  = ent_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        use1_d = use1_q;
        use2_d = use2_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--)
                ent_d[k] = ent_q[k-1];
            // The instruction leaving EX on a taken branch must never commit.
            if (flush)
                ent_d[1].valid = 1'b0;
            ent_d[0] = {issue, id_rd, id_regwrite, id_load};
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            use1_d   = id_use1;
            use2_d   = id_use2;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ent_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            use1_q <= 1'b0;
            use2_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            use1_q <= use1_d;
            use2_q <= use2_d;
        end
    end

`ifdef TINUC_HZD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold) begin
            if (stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
